user_obi_router: RTL and testbench
==================================

# user_obi_router

Address-decoding router for the user-domain OBI subordinate port. It fans the single crossbar-facing port out to `NumSbr` user peripherals and tracks outstanding transactions so responses return in order. Unmapped addresses are answered by a built-in error responder with data `32'hBADCAB1E`. It sits directly behind the user-domain port, between the crossbar and all user peripherals.

## Interface
- `NumSbr`, default 2: number of downstream user subordinates; must be at least 1.
- `MaxTrans`, default 2: maximum outstanding transactions; must be at least 1.
- `clk_i`, input, 1 bit: the single clock.
- `rst_ni`, input, 1 bit: asynchronous, active-low reset.
- `obi_req_i`, input, `sbr_obi_req_t`: request from the crossbar.
- `obi_rsp_o`, output, `sbr_obi_rsp_t`: response to the crossbar.
- `sbr_req_o`, output, `sbr_obi_req_t [NumSbr]`: requests to the peripherals.
- `sbr_rsp_i`, input, `sbr_obi_rsp_t [NumSbr]`: responses from the peripherals.
- `err_irq_o`, output, 1 bit: present only with `USER_OBI_ROUTER_ERR_IRQ_EN`.

## Operation
- **Decode.** Target `t` is the lowest `i` for which `(addr & UserSbrMask[i]) == UserSbrBase[i]`. If no entry matches, `t` is `NumSbr`, the internal error responder.
- **Forwarding.** `sbr_req_o[t]` carries `obi_req_i` unchanged. `req` is low on all other ports.
- **Grant.**
  - `obi_rsp_o.gnt = sbr_rsp_i[t].gnt & accept`.
  - For the error target, `gnt` is simply `accept`.
  - `accept = !full & (empty | t == last_t)`.
  - `last_t` is the target of the most recent handshake.
- **Blocked requests.** When `accept` is 0, `req` is not forwarded to any port. This stops a request from being granted downstream while it is blocked here.
- **Handshake** (`req & gnt`): push `t` into the route FIFO, which is `MaxTrans` deep. For the error target, also capture `aid`.
- **Response.**
  - `obi_rsp_o.r` is muxed from the FIFO head target.
  - `rvalid` from the head target pops the FIFO.
  - `rvalid` from any non-head port is ignored. The in-order rule makes this impossible in correct use.
- **Error responder.**
  - `rvalid` is asserted exactly 1 cycle after the handshake.
  - `rdata = 32'hBADCAB1E`, `err = 1`, `rid` = the captured `aid`.
  - It holds one pending response per FIFO entry.
- **Empty FIFO.** `obi_rsp_o.rvalid` is 0.
- **Full FIFO with a same-cycle pop.** `gnt` stays 0. There is no combinational path from `rvalid` to `gnt`.
- **Reset mid-operation.** The FIFO empties and pending error responses are dropped. Late peripheral `rvalid`s are ignored while the FIFO is empty.

## Timing
- Request path is combinational: `obi_req_i` to `sbr_req_o` in 0 cycles.
- Grant path is combinational: `sbr_rsp_i.gnt` to `obi_rsp_o.gnt` in 0 cycles.
- Response path is combinational: `sbr_rsp_i` to `obi_rsp_o` in 0 cycles.
- Peripheral latency passes through unchanged. Error response latency is 1 cycle.
- Back-to-back same-target transactions sustain 1 per cycle until the FIFO is full.
- Switching target stalls until all outstanding responses have returned (FIFO empty).
- Reset values:
  - `obi_rsp_o`: all zero.
  - `sbr_req_o`: all zero when `obi_req_i.req` is 0.
  - FIFO: empty, `last_t = 0`.
  - `err_irq_o = 0`.

## Configuration
- Macro: `USER_OBI_ROUTER_ERR_IRQ_EN`.
- **Defined:**
  - `err_irq_o` exists.
  - It pulses high for exactly 1 cycle, in the same cycle as each error-responder `rvalid`.
  - The user domain ORs it into `interrupts_o[0]`.
- **Undefined:**
  - The port and its logic are absent.
  - The user domain drives `interrupts_o` to `'0`.

## Structure
- **`croc_pkg` additions:**
  - `NumUserSbr`.
  - `UserSbrBase[NumUserSbr]` and `UserSbrMask[NumUserSbr]` (32-bit).
  - `user_sbr_idx_t`, `$clog2(NumUserSbr+1)` bits wide.
  - `UserErrData = 32'hBADCAB1E`.
  - Default map:
    - sbr0: base `0x2000_0000`, mask `0xFFFF_F000`.
    - sbr1: base `0x2000_1000`, mask `0xFFFF_F000`.
- **Sub-module `user_obi_route_fifo`:**
  - Depth `MaxTrans`, storing `user_sbr_idx_t` plus `aid`.
  - Provides `full`, `empty`, `push`, `pop` and `head`.
  - Pointer wrap at `MaxTrans` is a modulo wrap and must work for non-power-of-2 depths.

## Test plan
- **Read to sbr0.** Read `0x2000_0004`; sbr0 grants at once and returns `0x1234_5678` after 2 cycles. Expect `obi_rsp_o.rdata = 0x1234_5678`, `err = 0`, and no `req` on sbr1.
- **Unmapped write.** Write to `0x2000_8000` with `aid = 3`. Expect `gnt` in the same cycle, then `rvalid` 1 cycle later with `err = 1`, `rdata = 0xBADCAB1E`, `rid = 3`. With the macro defined, `err_irq_o` is high for that one cycle.
- **Same-target pipelining.** Send 3 back-to-back reads to sbr1 with `MaxTrans = 2`. Expect the first two granted on consecutive cycles, the third held with `gnt = 0` until the first `rvalid`, then granted the following cycle.
- **Target switch.** Read sbr0, then immediately read sbr1. Expect the sbr1 `req` to stay low until the sbr0 `rvalid`. Responses arrive in order sbr0, then sbr1.
- **Reset mid-operation.** Assert `rst_ni` low with 2 transactions outstanding. Expect the FIFO empty and `rvalid = 0`; a late `rvalid` from sbr0 after release does not reach `obi_rsp_o`.
- **Full plus pop.** With the FIFO full, the head `rvalid` and a new request arrive in the same cycle. Expect `gnt = 0` in that cycle and `gnt = 1` in the next.

Source files
------------

// File: rtl/user_obi_router_pkg.sv
// user_obi_router_pkg: shared OBI types, user address map and decode helper.
//   Types : sbr_obi_req_t, sbr_obi_rsp_t, user_sbr_idx_t
//   Map   : NumUserSbr entries of UserSbrBase/UserSbrMask, UserErrData
//   Func  : user_sbr_decode(addr, n) -> lowest matching index, or n if unmapped
package user_obi_router_pkg;
   localparam int IdW        = 3;
   localparam int NumUserSbr = 2;
   localparam logic [NumUserSbr-1:0][31:0] UserSbrBase = {32'h2000_1000, 32'h2000_0000};
   localparam logic [NumUserSbr-1:0][31:0] UserSbrMask = {32'hFFFF_F000, 32'hFFFF_F000};
   localparam logic [31:0] UserErrData = 32'hBADCAB1E;
   typedef logic [$clog2(NumUserSbr+1)-1:0] user_sbr_idx_t;
   typedef struct packed {
      logic           req;
      logic [31:0]    addr;
      logic           we;
      logic [3:0]     be;
      logic [31:0]    wdata;
      logic [IdW-1:0] aid;
   } sbr_obi_req_t;
   typedef struct packed {
      logic           gnt;
      logic           rvalid;
      logic [31:0]    rdata;
      logic [IdW-1:0] rid;
      logic           err;
   } sbr_obi_rsp_t;
   // Scan from the top down so the lowest matching entry wins.
   function automatic user_sbr_idx_t user_sbr_decode(input logic [31:0] addr, input int n);
      user_sbr_idx_t t;
      t = user_sbr_idx_t'(n);
      for (int i = n - 1; i >= 0; i--)
         if ((addr & UserSbrMask[i]) == UserSbrBase[i]) t = user_sbr_idx_t'(i);
      return t;
   endfunction
endpackage

// File: rtl/user_obi_route_fifo.sv
// user_obi_route_fifo: in-order queue of routed targets and request ids.
//   clk_i, rst_ni      : clock, async active-low reset
//   push, push_idx/aid : enqueue a handshaken transaction
//   pop                : dequeue the head on its response
//   full, empty        : occupancy flags
//   head_idx, head_aid : oldest outstanding transaction
module user_obi_route_fifo
   import user_obi_router_pkg::*;
#(
   parameter int Depth = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push,
   input  user_sbr_idx_t  push_idx,
   input  logic [IdW-1:0] push_aid,
   input  logic           pop,
   output logic           full,
   output logic           empty,
   output user_sbr_idx_t  head_idx,
   output logic [IdW-1:0] head_aid
);
   localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   logic [PtrW-1:0] rptr, wptr;
   logic [CntW-1:0] cnt;
   logic            do_push, do_pop;
   user_sbr_idx_t   idx_mem [Depth];
   logic [IdW-1:0]  aid_mem [Depth];
   // Explicit modulo wrap keeps non-power-of-2 depths correct.
   function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
      return p == PtrW'(Depth - 1) ? '0 : p + PtrW'(1);
   endfunction
   assign full     = cnt == CntW'(Depth);
   assign empty    = cnt == '0;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign head_idx = idx_mem[rptr];
   assign head_aid = aid_mem[rptr];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= nxt(wptr);
         if (do_pop) rptr <= nxt(rptr);
         cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         idx_mem[wptr] <= push_idx;
         aid_mem[wptr] <= push_aid;
      end
   end
endmodule

// File: rtl/user_obi_router.sv
// user_obi_router: address-decoding OBI router for the user domain with in-order response tracking.
//   clk_i, rst_ni : clock, async active-low reset
//   obi_req_i/rsp : crossbar-facing subordinate port
//   sbr_req_o/rsp : NumSbr peripheral ports
//   err_irq_o     : error-response pulse, only with USER_OBI_ROUTER_ERR_IRQ_EN
// Unmapped addresses go to an internal responder (index NumSbr) returning UserErrData.
module user_obi_router
   import user_obi_router_pkg::*;
#(
   parameter int NumSbr   = NumUserSbr,
   parameter int MaxTrans = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  sbr_obi_req_t obi_req_i,
   output sbr_obi_rsp_t obi_rsp_o,
   output sbr_obi_req_t sbr_req_o [NumSbr],
   input  sbr_obi_rsp_t sbr_rsp_i [NumSbr]
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
   ,
   output logic         err_irq_o
`endif
);
   localparam user_sbr_idx_t ErrIdx = user_sbr_idx_t'(NumSbr);
   user_sbr_idx_t  t, last_t, head_idx;
   logic [IdW-1:0] head_aid;
   logic           full, empty, accept, tgt_gnt, hs, err_pend;
   assign t      = user_sbr_decode(obi_req_i.addr, NumSbr);
   // Only follow-on requests to the same target may overlap; a switch waits for drain.
   assign accept = ~full & (empty | t == last_t);
   assign hs     = obi_req_i.req & obi_rsp_o.gnt;
   always_comb begin
      tgt_gnt = t == ErrIdx;
      for (int i = 0; i < NumSbr; i++)
         if (user_sbr_idx_t'(i) == t) tgt_gnt = sbr_rsp_i[i].gnt;
   end
   always_comb begin
      for (int i = 0; i < NumSbr; i++) begin
         sbr_req_o[i] = '0;
         if (obi_req_i.req && user_sbr_idx_t'(i) == t) begin
            sbr_req_o[i]     = obi_req_i;
            sbr_req_o[i].req = accept;
         end
      end
   end
   // Response comes only from the FIFO head; stray rvalids elsewhere are dropped.
   always_comb begin
      obi_rsp_o     = '0;
      obi_rsp_o.gnt = obi_req_i.req & accept & tgt_gnt;
      if (!empty && head_idx == ErrIdx && err_pend) begin
         obi_rsp_o.rvalid = 1'b1;
         obi_rsp_o.rdata  = UserErrData;
         obi_rsp_o.rid    = head_aid;
         obi_rsp_o.err    = 1'b1;
      end
      for (int i = 0; i < NumSbr; i++)
         if (!empty && user_sbr_idx_t'(i) == head_idx) begin
            obi_rsp_o.rvalid = sbr_rsp_i[i].rvalid;
            obi_rsp_o.rdata  = sbr_rsp_i[i].rdata;
            obi_rsp_o.rid    = sbr_rsp_i[i].rid;
            obi_rsp_o.err    = sbr_rsp_i[i].err;
         end
   end
   // Error entries are only queued behind other error entries, each popping the
   // cycle after its handshake, so a one-cycle flag always refers to the head.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_t   <= '0;
         err_pend <= 1'b0;
      end else begin
         err_pend <= hs & (t == ErrIdx);
         if (hs) last_t <= t;
      end
   end
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
   assign err_irq_o = err_pend;
`endif
   user_obi_route_fifo #(.Depth(MaxTrans)) u_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push     (hs),
      .push_idx (t),
      .push_aid (obi_req_i.aid),
      .pop      (obi_rsp_o.rvalid),
      .full     (full),
      .empty    (empty),
      .head_idx (head_idx),
      .head_aid (head_aid)
   );
endmodule

// File: tb/tb_user_obi_router.sv
// tb_user_obi_router: directed vector table plus multi-cycle sequences for user_obi_router.
module tb_user_obi_router;
   import user_obi_router_pkg::*;
   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   sbr_obi_req_t obi_req;
   sbr_obi_rsp_t obi_rsp;
   sbr_obi_req_t sbr_req [2];
   sbr_obi_rsp_t sbr_rsp [2];
   int checks = 0;
   int errors = 0;
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
   logic err_irq;
`endif
   user_obi_router #(.NumSbr(2), .MaxTrans(2)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .obi_req_i (obi_req),
      .obi_rsp_o (obi_rsp),
      .sbr_req_o (sbr_req),
      .sbr_rsp_i (sbr_rsp)
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
      ,
      .err_irq_o (err_irq)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        g0, g1;
      logic        r0, r1, gnt;
   } vec_t;
   vec_t vecs [10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [IdW-1:0] id);
      obi_req.req   = r;
      obi_req.we    = w;
      obi_req.addr  = a;
      obi_req.aid   = id;
      obi_req.be    = 4'hF;
      obi_req.wdata = 32'h0;
   endtask
   task automatic prsp(input int i, input logic g, input logic v, input logic [31:0] d, input logic [IdW-1:0] id);
      sbr_rsp[i].gnt    = g;
      sbr_rsp[i].rvalid = v;
      sbr_rsp[i].rdata  = d;
      sbr_rsp[i].rid    = id;
      sbr_rsp[i].err    = 1'b0;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      vecs[0] = '{1'b0, 32'h2000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h2000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 32'h2000_0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h2000_1FFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 32'h2000_1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'h2000_8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 32'h1FFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 32'h2000_2000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 32'h2000_0FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 32'h2000_8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      prsp(1, 1'b0, 1'b0, 32'h0, '0);
      // Reset held: FIFO stays empty, so the combinational decode/grant paths are isolated.
      #2;
      chk("reset_rsp", 32'(obi_rsp), 32'h0);
      chk("reset_sbr0", 32'(sbr_req[0]), 32'h0);
      chk("reset_sbr1", 32'(sbr_req[1]), 32'h0);
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].req, 1'b0, vecs[i].addr, 3'd1);
         prsp(0, vecs[i].g0, 1'b0, 32'h0, '0);
         prsp(1, vecs[i].g1, 1'b0, 32'h0, '0);
         #1;
         chk($sformatf("vec%0d_req0", i), 32'(sbr_req[0].req), 32'(vecs[i].r0));
         chk($sformatf("vec%0d_req1", i), 32'(sbr_req[1].req), 32'(vecs[i].r1));
         chk($sformatf("vec%0d_gnt", i), 32'(obi_rsp.gnt), 32'(vecs[i].gnt));
         if (vecs[i].r0) chk($sformatf("vec%0d_addr0", i), sbr_req[0].addr, vecs[i].addr);
         if (vecs[i].r1) chk($sformatf("vec%0d_addr1", i), sbr_req[1].addr, vecs[i].addr);
      end
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      prsp(1, 1'b0, 1'b0, 32'h0, '0);
      cyc();
      rst_ni = 1'b1;
      // Read to sbr0, data two cycles after handshake.
      cyc();
      drive(1'b1, 1'b0, 32'h2000_0004, 3'd1);
      prsp(0, 1'b1, 1'b0, 32'h0, '0);
      #1;
      chk("rd0_gnt", 32'(obi_rsp.gnt), 32'h1);
      chk("rd0_req0", 32'(sbr_req[0].req), 32'h1);
      chk("rd0_req1", 32'(sbr_req[1].req), 32'h0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("rd0_wait", 32'(obi_rsp.rvalid), 32'h0);
      cyc();
      prsp(0, 1'b0, 1'b1, 32'h1234_5678, 3'd1);
      #1;
      chk("rd0_rvalid", 32'(obi_rsp.rvalid), 32'h1);
      chk("rd0_rdata", obi_rsp.rdata, 32'h1234_5678);
      chk("rd0_err", 32'(obi_rsp.err), 32'h0);
      chk("rd0_rid", 32'(obi_rsp.rid), 32'h1);
      cyc();
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("rd0_done", 32'(obi_rsp.rvalid), 32'h0);
      // Unmapped write answered by the error responder.
      cyc();
      drive(1'b1, 1'b1, 32'h2000_8000, 3'd3);
      #1;
      chk("err_gnt", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("err_rvalid", 32'(obi_rsp.rvalid), 32'h1);
      chk("err_err", 32'(obi_rsp.err), 32'h1);
      chk("err_rdata", obi_rsp.rdata, 32'hBADCAB1E);
      chk("err_rid", 32'(obi_rsp.rid), 32'h3);
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
      chk("err_irq_hi", 32'(err_irq), 32'h1);
`endif
      cyc();
      chk("err_done", 32'(obi_rsp.rvalid), 32'h0);
`ifdef USER_OBI_ROUTER_ERR_IRQ_EN
      chk("err_irq_lo", 32'(err_irq), 32'h0);
`endif
      // Three same-target reads with MaxTrans=2, including full plus same-cycle pop.
      cyc();
      drive(1'b1, 1'b0, 32'h2000_1000, 3'd0);
      prsp(1, 1'b1, 1'b0, 32'h0, '0);
      #1;
      chk("pipe_gnt1", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b1, 1'b0, 32'h2000_1004, 3'd1);
      #1;
      chk("pipe_gnt2", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b1, 1'b0, 32'h2000_1008, 3'd2);
      #1;
      chk("pipe_full_gnt", 32'(obi_rsp.gnt), 32'h0);
      chk("pipe_full_req1", 32'(sbr_req[1].req), 32'h0);
      cyc();
      prsp(1, 1'b1, 1'b1, 32'hA000_0001, 3'd0);
      #1;
      chk("pipe_pop_gnt", 32'(obi_rsp.gnt), 32'h0);
      chk("pipe_r1", obi_rsp.rdata, 32'hA000_0001);
      chk("pipe_r1_v", 32'(obi_rsp.rvalid), 32'h1);
      cyc();
      prsp(1, 1'b1, 1'b0, 32'h0, '0);
      #1;
      chk("pipe_gnt3", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(1, 1'b0, 1'b1, 32'hA000_0002, 3'd1);
      #1;
      chk("pipe_r2", obi_rsp.rdata, 32'hA000_0002);
      cyc();
      prsp(1, 1'b0, 1'b1, 32'hA000_0003, 3'd2);
      #1;
      chk("pipe_r3", obi_rsp.rdata, 32'hA000_0003);
      chk("pipe_r3_rid", 32'(obi_rsp.rid), 32'h2);
      cyc();
      prsp(1, 1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("pipe_empty", 32'(obi_rsp.rvalid), 32'h0);
      // Target switch waits for the sbr0 response to drain.
      cyc();
      drive(1'b1, 1'b0, 32'h2000_0010, 3'd4);
      prsp(0, 1'b1, 1'b0, 32'h0, '0);
      prsp(1, 1'b1, 1'b0, 32'h0, '0);
      #1;
      chk("sw_gnt0", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b1, 1'b0, 32'h2000_1010, 3'd5);
      #1;
      chk("sw_blk_req1", 32'(sbr_req[1].req), 32'h0);
      chk("sw_blk_gnt", 32'(obi_rsp.gnt), 32'h0);
      cyc();
      prsp(0, 1'b1, 1'b1, 32'hAAAA_0000, 3'd4);
      #1;
      chk("sw_r0", obi_rsp.rdata, 32'hAAAA_0000);
      chk("sw_r0_req1", 32'(sbr_req[1].req), 32'h0);
      cyc();
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      #1;
      chk("sw_req1", 32'(sbr_req[1].req), 32'h1);
      chk("sw_gnt1", 32'(obi_rsp.gnt), 32'h1);
      cyc();
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(1, 1'b0, 1'b1, 32'hBBBB_0000, 3'd5);
      #1;
      chk("sw_r1", obi_rsp.rdata, 32'hBBBB_0000);
      chk("sw_r1_rid", 32'(obi_rsp.rid), 32'h5);
      cyc();
      prsp(1, 1'b0, 1'b0, 32'h0, '0);
      // Reset with two transactions outstanding to sbr0.
      cyc();
      drive(1'b1, 1'b0, 32'h2000_0020, 3'd6);
      prsp(0, 1'b1, 1'b0, 32'h0, '0);
      cyc();
      drive(1'b1, 1'b0, 32'h2000_0024, 3'd7);
      cyc();
      drive(1'b0, 1'b0, 32'h0, '0);
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      rst_ni = 1'b0;
      #1;
      chk("rst_rvalid", 32'(obi_rsp.rvalid), 32'h0);
      cyc();
      rst_ni = 1'b1;
      cyc();
      prsp(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd6);
      #1;
      chk("rst_late_rvalid", 32'(obi_rsp.rvalid), 32'h0);
      chk("rst_late_rdata", obi_rsp.rdata, 32'h0);
      cyc();
      prsp(0, 1'b0, 1'b0, 32'h0, '0);
      drive(1'b1, 1'b0, 32'h2000_1000, 3'd0);
      prsp(1, 1'b1, 1'b0, 32'h0, '0);
      #1;
      chk("rst_empty_gnt", 32'(obi_rsp.gnt), 32'h1);
      drive(1'b0, 1'b0, 32'h0, '0);
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
